ex_mem_stage_buf: RTL and testbench
===================================

Name: ex_mem_stage_buf

Overview:
Parametrised EX→MEM pipeline stage that carries the memory and writeback controls, the ALU result, the store value and the destination register.
Generalises the plain 71-bit stage register:
- data and destination widths are set by parameters;
- adds a valid/ready handshake, an optional 2-entry skid buffer, freeze (stall) and flush (bubble insertion).
Sits between the EX stage and the MEM stage. The hazard/forwarding unit drives freeze and flush.

Parameters:
DATA_W, 32, width of alu_res and rm_val
DEST_W, 4, width of dest (register index)
SKID_EN, 1, 1 = 2-entry skid with registered in_ready; 0 = single entry with combinational in_ready

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-low reset
freeze  in  1  global stall: no transfer on either side; all state held
flush  in  1  discard all held entries and any input offered this cycle
in_valid  in  1  EX offers an entry
in_ready  out  1  stage can accept an entry
wb_en_in, mem_r_en_in, mem_w_en_in  in  1 each  control bits
alu_res_in  in  DATA_W  ALU result / address
rm_val_in  in  DATA_W  store data
dest_in  in  DEST_W  writeback register
out_valid  out  1  MEM sees a valid entry
out_ready  in  1  MEM consumes the entry
wb_en_out, mem_r_en_out, mem_w_en_out  out  1 each  control bits, forced 0 when out_valid=0
alu_res_out, rm_val_out  out  DATA_W  payload of head entry
dest_out  out  DEST_W  payload of head entry
occupancy  out  2  entries held: 0..2; 0..1 when SKID_EN=0

Behaviour:
- Storage: head slot (drives the outputs) and, when SKID_EN=1, a skid slot. Each slot holds a valid bit, 3 control bits and the payload.
- Handshake events:
  - accept = in_valid & in_ready & ~freeze
  - pop = out_valid & out_ready & ~freeze
- Reset (rst=0 at the clock edge):
  - all valid bits 0, control bits 0, payload 0, occupancy 0;
  - in_ready = 1 on the first cycle after reset.
- Priority: rst > flush > freeze > normal operation.
- Flush:
  - next edge clears both valid bits and all control bits; the payload is don't-care;
  - an input offered in the same cycle is dropped;
  - freeze is ignored in a flush cycle.
- Freeze: every register holds; accept=0 and pop=0 regardless of in_valid and out_ready.
- Latency: an entry accepted at edge N is visible on the outputs after edge N. Throughput is 1 per cycle while out_ready=1.
- SKID_EN=1:
  - in_ready is registered: in_ready = ~skid_valid.
  - head empty or popped, skid empty → an accepted entry goes to head.
  - head full and not popped, accept → entry goes to skid; in_ready falls the next cycle.
  - pop with skid full → head ← skid and skid empties. A simultaneous accept cannot occur because in_ready=0.
  - Ordering is FIFO; no entry is lost or duplicated.
- SKID_EN=0:
  - in_ready = ~head_valid | (out_ready & ~freeze), combinational;
  - pop and accept in the same cycle replace the head entry.
- Output gating:
  - wb_en_out, mem_r_en_out, mem_w_en_out = stored bits & out_valid;
  - payload outputs hold their last value when out_valid=0.
- Occupancy:
  - equals head_valid + skid_valid;
  - changes by at most 1 per cycle, except a flush, which takes it to 0 from any value.

Decomposition:
- Shared package:
  - ctrl bundle typedef {wb_en, mem_r_en, mem_w_en};
  - CTRL_W=3;
  - default widths DATA_W_DEF=32, DEST_W_DEF=4.
- One sub-module: stage_slot.
  - A valid + ctrl + payload register with load, clear and hold, and synchronous active-low reset.
  - Instantiated as the head slot, and as the skid slot when SKID_EN=1.

Test Plan:
- Reset: rst=0 for 2 cycles, then release → out_valid=0, occupancy=0, all control outputs 0, in_ready=1.
- Streaming: accept alu_res 0x10, 0x20, 0x30 on consecutive cycles with out_ready=1 → the outputs show the same values one cycle later each, in order, with occupancy held at 1.
- Backpressure (SKID_EN=1):
  - head holds 0xA, out_ready=0, accept 0xB → occupancy=2 and in_ready=0 next cycle;
  - out_ready=1 → outputs 0xA then 0xB, and in_ready returns to 1 one cycle after the skid drains.
- Freeze: occupancy=2 with freeze=1 and out_ready=1 held for 3 cycles → outputs, occupancy and in_ready unchanged, no pop.
- Flush:
  - occupancy=2, flush=1 together with in_valid=1 carrying mem_w_en=1 → next cycle occupancy=0, out_valid=0, mem_w_en_out=0, and the offered entry is never output;
  - repeat with freeze=1 in the same cycle → same result.
- SKID_EN=0 with DATA_W=64, DEST_W=5:
  - head full, out_ready=1, in_valid=1 with alu_res 0xFFFF_FFFF_0000_0001 → in_ready=1 in the same cycle, and the head is replaced at the next edge;
  - with out_ready=0 → in_ready=0.

Source files
------------

// File: rtl/ex_mem_stage_buf_pkg.sv
// Shared types and default widths for the EX->MEM stage buffer.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package ex_mem_stage_buf_pkg;

    localparam int CTRL_W     = 3;
    localparam int DATA_W_DEF = 32;
    localparam int DEST_W_DEF = 4;

    // Memory and writeback controls that travel with every entry
    typedef struct packed {
        logic wbEn;
        logic memREn;
        logic memWEn;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

    // A bubble must never carry live controls into MEM
    function automatic ctrl_t gateCtrl(input ctrl_t c, input logic v);
        return v ? c : CTRL_NONE;
    endfunction

endpackage

// File: rtl/ex_mem_stage_buf_if.sv
// One valid/ready link carrying controls, ALU result, store value and destination register.
// Latency: wires only.
// Backpressure: the consumer drives ready; the producer holds its offer until ready is seen.
interface ex_mem_stage_buf_if
    import ex_mem_stage_buf_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEST_W = DEST_W_DEF
);

    logic              valid;
    logic              ready;
    ctrl_t             ctrl;
    logic [DATA_W-1:0] aluRes;
    logic [DATA_W-1:0] rmVal;
    logic [DEST_W-1:0] dest;

    modport master (
        output valid,
        output ctrl,
        output aluRes,
        output rmVal,
        output dest,
        input  ready
    );

    modport slave (
        input  valid,
        input  ctrl,
        input  aluRes,
        input  rmVal,
        input  dest,
        output ready
    );

endinterface

// File: rtl/ex_mem_stage_buf_stage_slot.sv
// One stage entry register: valid bit, control bits and payload.
// Latency: load/clear take effect at the next rising edge.
// Backpressure: none; the parent decides when to load, clear or hold.
module stage_slot
    import ex_mem_stage_buf_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEST_W = DEST_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  ctrl_t             ctrlIn,
    input  logic [DATA_W-1:0] aluResIn,
    input  logic [DATA_W-1:0] rmValIn,
    input  logic [DEST_W-1:0] destIn,
    output logic              valid,
    output ctrl_t             ctrl,
    output logic [DATA_W-1:0] aluRes,
    output logic [DATA_W-1:0] rmVal,
    output logic [DEST_W-1:0] dest
);

    // Clear wins over load; a clear keeps the payload so the outputs stay quiet
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid  <= 1'b0;
            ctrl   <= CTRL_NONE;
            aluRes <= '0;
            rmVal  <= '0;
            dest   <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            ctrl  <= CTRL_NONE;
        end else if (load) begin
            valid  <= 1'b1;
            ctrl   <= ctrlIn;
            aluRes <= aluResIn;
            rmVal  <= rmValIn;
            dest   <= destIn;
        end
    end

endmodule

// File: rtl/ex_mem_stage_buf.sv
// EX->MEM pipeline stage with valid/ready handshake, optional 2-entry skid, freeze and flush.
// Latency: an entry accepted at edge N drives the MEM side after edge N; 1 entry/cycle sustained.
// Backpressure: skid mode gives a registered ready (~skid full); no-skid mode gives a combinational ready.
module ex_mem_stage_buf
    import ex_mem_stage_buf_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int DEST_W  = DEST_W_DEF,
    parameter int SKID_EN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        flush,
    ex_mem_stage_buf_if.slave  exIf,
    ex_mem_stage_buf_if.master memIf,
    output logic [1:0]  occupancy
);

    logic              accept;
    logic              pop;
    logic              inReady;

    logic              headLoad;
    logic              headClear;
    logic              skidLoad;
    logic              skidClear;

    logic              headValid;
    ctrl_t             headCtrl;
    logic [DATA_W-1:0] headAlu;
    logic [DATA_W-1:0] headRm;
    logic [DEST_W-1:0] headDest;

    logic              skidValid;
    ctrl_t             skidCtrl;
    logic [DATA_W-1:0] skidAlu;
    logic [DATA_W-1:0] skidRm;
    logic [DEST_W-1:0] skidDest;

    ctrl_t             headCtrlIn;
    logic [DATA_W-1:0] headAluIn;
    logic [DATA_W-1:0] headRmIn;
    logic [DEST_W-1:0] headDestIn;

    // Qualify both handshakes and steer entries: the head refills from the skid first, else from EX
    always_comb begin
        accept     = exIf.valid & inReady & ~freeze;
        pop        = headValid & memIf.ready & ~freeze;
        // With the skid full, ready is low so accept cannot coincide with a skid drain
        headLoad   = (pop & skidValid) | (accept & (~headValid | pop));
        headClear  = flush | (pop & ~headLoad);
        skidLoad   = accept & headValid & ~pop;
        skidClear  = flush | (pop & skidValid);
        headCtrlIn = skidValid ? skidCtrl : exIf.ctrl;
        headAluIn  = skidValid ? skidAlu  : exIf.aluRes;
        headRmIn   = skidValid ? skidRm   : exIf.rmVal;
        headDestIn = skidValid ? skidDest : exIf.dest;
    end

    stage_slot #(
        .DATA_W (DATA_W),
        .DEST_W (DEST_W)
    ) headSlot (
        .clk      (clk),
        .rst      (rst),
        .load     (headLoad),
        .clear    (headClear),
        .ctrlIn   (headCtrlIn),
        .aluResIn (headAluIn),
        .rmValIn  (headRmIn),
        .destIn   (headDestIn),
        .valid    (headValid),
        .ctrl     (headCtrl),
        .aluRes   (headAlu),
        .rmVal    (headRm),
        .dest     (headDest)
    );

    generate
        if (SKID_EN != 0) begin : gSkid
            stage_slot #(
                .DATA_W (DATA_W),
                .DEST_W (DEST_W)
            ) skidSlot (
                .clk      (clk),
                .rst      (rst),
                .load     (skidLoad),
                .clear    (skidClear),
                .ctrlIn   (exIf.ctrl),
                .aluResIn (exIf.aluRes),
                .rmValIn  (exIf.rmVal),
                .destIn   (exIf.dest),
                .valid    (skidValid),
                .ctrl     (skidCtrl),
                .aluRes   (skidAlu),
                .rmVal    (skidRm),
                .dest     (skidDest)
            );
            // Ready comes straight from a flop, which breaks the ready path back into EX
            assign inReady = ~skidValid;
        end else begin : gNoSkid
            assign skidValid = 1'b0;
            assign skidCtrl  = CTRL_NONE;
            assign skidAlu   = '0;
            assign skidRm    = '0;
            assign skidDest  = '0;
            // Single entry: accept only if the head is empty or leaving this cycle
            assign inReady   = ~headValid | (memIf.ready & ~freeze);
        end
    endgenerate

    assign exIf.ready   = inReady;

    assign memIf.valid  = headValid;
    assign memIf.ctrl   = gateCtrl(headCtrl, headValid);
    assign memIf.aluRes = headAlu;
    assign memIf.rmVal  = headRm;
    assign memIf.dest   = headDest;

    assign occupancy    = {1'b0, headValid} + {1'b0, skidValid};

endmodule

// File: tb/tb_ex_mem_stage_buf.sv
// Bench for ex_mem_stage_buf: a skid instance (32/4) and a no-skid instance (64/5).
// Latency: entries are scored when popped on the MEM side.
// Backpressure: out_ready, freeze and flush are driven from the stimulus sequence.
module tb_ex_mem_stage_buf;
    import ex_mem_stage_buf_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       freezeA, flushA, freezeB, flushB;
    logic [1:0] occA, occB;

    ex_mem_stage_buf_if #(.DATA_W(32), .DEST_W(4)) exA ();
    ex_mem_stage_buf_if #(.DATA_W(32), .DEST_W(4)) memA ();
    ex_mem_stage_buf_if #(.DATA_W(64), .DEST_W(5)) exB ();
    ex_mem_stage_buf_if #(.DATA_W(64), .DEST_W(5)) memB ();

    ex_mem_stage_buf #(.DATA_W(32), .DEST_W(4), .SKID_EN(1)) dutA (
        .clk(clk), .rst(rst), .freeze(freezeA), .flush(flushA),
        .exIf(exA), .memIf(memA), .occupancy(occA)
    );

    ex_mem_stage_buf #(.DATA_W(64), .DEST_W(5), .SKID_EN(0)) dutB (
        .clk(clk), .rst(rst), .freeze(freezeB), .flush(flushB),
        .exIf(exB), .memIf(memB), .occupancy(occB)
    );

    typedef struct {
        logic [2:0]  ctrl;
        logic [63:0] alu;
        logic [63:0] rm;
        logic [4:0]  dest;
    } ent_t;

    ent_t qA[$];
    ent_t qB[$];

    int nAsserts = 0;
    int nFails   = 0;

    task automatic checkVal(input string tag, input logic [63:0] act, input logic [63:0] exp);
        nAsserts++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drvA(input logic v, input logic [2:0] c, input logic [31:0] alu);
        exA.valid  = v;
        exA.ctrl   = ctrl_t'(c);
        exA.aluRes = alu;
        exA.rmVal  = ~alu;
        exA.dest   = alu[3:0] ^ 4'h5;
    endtask

    task automatic drvB(input logic v, input logic [2:0] c, input logic [63:0] alu, input logic [4:0] d);
        exB.valid  = v;
        exB.ctrl   = ctrl_t'(c);
        exB.aluRes = alu;
        exB.rmVal  = alu ^ 64'h5A5A_5A5A_5A5A_5A5A;
        exB.dest   = d;
    endtask

    // Scoreboard for the skid instance: push on accept, compare on pop, drop all on flush
    always @(negedge clk) begin
        ent_t e;
        if (!rst) begin
            qA.delete();
        end else begin
            if (memA.valid && memA.ready && !freezeA && !flushA) begin
                checkVal("A_popHasEntry", 64'(qA.size() != 0), 64'd1);
                if (qA.size() != 0) begin
                    e = qA.pop_front();
                    checkVal("A_popCtrl", 64'(memA.ctrl), 64'(e.ctrl));
                    checkVal("A_popAlu",  64'(memA.aluRes), e.alu);
                    checkVal("A_popRm",   64'(memA.rmVal), e.rm);
                    checkVal("A_popDest", 64'(memA.dest), 64'(e.dest));
                end
            end
            if (exA.valid && exA.ready && !freezeA && !flushA) begin
                e.ctrl = exA.ctrl;
                e.alu  = 64'(exA.aluRes);
                e.rm   = 64'(exA.rmVal);
                e.dest = 5'(exA.dest);
                qA.push_back(e);
            end
            if (flushA) qA.delete();
        end
    end

    // Scoreboard for the no-skid instance
    always @(negedge clk) begin
        ent_t e;
        if (!rst) begin
            qB.delete();
        end else begin
            if (memB.valid && memB.ready && !freezeB && !flushB) begin
                checkVal("B_popHasEntry", 64'(qB.size() != 0), 64'd1);
                if (qB.size() != 0) begin
                    e = qB.pop_front();
                    checkVal("B_popCtrl", 64'(memB.ctrl), 64'(e.ctrl));
                    checkVal("B_popAlu",  memB.aluRes, e.alu);
                    checkVal("B_popRm",   memB.rmVal, e.rm);
                    checkVal("B_popDest", 64'(memB.dest), 64'(e.dest));
                end
            end
            if (exB.valid && exB.ready && !freezeB && !flushB) begin
                e.ctrl = exB.ctrl;
                e.alu  = exB.aluRes;
                e.rm   = exB.rmVal;
                e.dest = exB.dest;
                qB.push_back(e);
            end
            if (flushB) qB.delete();
        end
    end

    initial begin
        rst = 1'b0; freezeA = 1'b0; flushA = 1'b0; freezeB = 1'b0; flushB = 1'b0;
        drvA(1'b0, 3'b000, 32'h0);
        drvB(1'b0, 3'b000, 64'h0, 5'h0);
        memA.ready = 1'b0;
        memB.ready = 1'b0;
        step();
        step();
        rst = 1'b1;

        // Reset state, then stream 0x10/0x20/0x30 with MEM always ready
        memA.ready = 1'b1;
        drvA(1'b1, 3'b100, 32'h10);
        @(negedge clk);
        checkVal("rst_outValidA", 64'(memA.valid), 64'd0);
        checkVal("rst_occA",      64'(occA), 64'd0);
        checkVal("rst_ctrlA",     64'(memA.ctrl), 64'd0);
        checkVal("rst_inReadyA",  64'(exA.ready), 64'd1);
        checkVal("rst_occB",      64'(occB), 64'd0);
        checkVal("rst_inReadyB",  64'(exB.ready), 64'd1);
        step();
        drvA(1'b1, 3'b010, 32'h20);
        @(negedge clk);
        checkVal("stream_occ1", 64'(occA), 64'd1);
        checkVal("stream_alu1", 64'(memA.aluRes), 64'h10);
        step();
        drvA(1'b1, 3'b001, 32'h30);
        @(negedge clk);
        checkVal("stream_occ2", 64'(occA), 64'd1);
        checkVal("stream_alu2", 64'(memA.aluRes), 64'h20);
        step();
        drvA(1'b0, 3'b000, 32'h0);
        @(negedge clk);
        checkVal("stream_occ3", 64'(occA), 64'd1);
        checkVal("stream_alu3", 64'(memA.aluRes), 64'h30);
        step();

        // Backpressure: A held, B lands in the skid
        memA.ready = 1'b0;
        drvA(1'b1, 3'b100, 32'hA);
        @(negedge clk);
        checkVal("drain_valid",   64'(memA.valid), 64'd0);
        checkVal("drain_ctrlGate", 64'(memA.ctrl), 64'd0);
        checkVal("drain_aluHold", 64'(memA.aluRes), 64'h30);
        step();
        drvA(1'b1, 3'b010, 32'hB);
        @(negedge clk);
        checkVal("bp_occ1",     64'(occA), 64'd1);
        checkVal("bp_inReady1", 64'(exA.ready), 64'd1);
        step();
        drvA(1'b0, 3'b000, 32'h0);
        @(negedge clk);
        checkVal("bp_occ2",     64'(occA), 64'd2);
        checkVal("bp_inReady0", 64'(exA.ready), 64'd0);
        checkVal("bp_headA",    64'(memA.aluRes), 64'hA);
        step();
        memA.ready = 1'b1;
        @(negedge clk);
        checkVal("bp_headStillA", 64'(memA.aluRes), 64'hA);
        step();
        @(negedge clk);
        checkVal("bp_headB",        64'(memA.aluRes), 64'hB);
        checkVal("bp_occAfterPop",  64'(occA), 64'd1);
        checkVal("bp_inReadyBack",  64'(exA.ready), 64'd1);
        step();

        // Fill to two entries, then freeze with MEM ready and EX offering
        memA.ready = 1'b0;
        drvA(1'b1, 3'b001, 32'hC);
        @(negedge clk);
        checkVal("fill_empty", 64'(occA), 64'd0);
        step();
        drvA(1'b1, 3'b111, 32'hD);
        step();
        freezeA = 1'b1;
        memA.ready = 1'b1;
        drvA(1'b1, 3'b111, 32'hE);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkVal("frz_occ",     64'(occA), 64'd2);
            checkVal("frz_inReady", 64'(exA.ready), 64'd0);
            checkVal("frz_alu",     64'(memA.aluRes), 64'hC);
            checkVal("frz_memW",    64'(memA.ctrl.memWEn), 64'd1);
            step();
        end

        // Flush from occupancy 2 while EX offers a store
        freezeA = 1'b0;
        memA.ready = 1'b0;
        flushA = 1'b1;
        drvA(1'b1, 3'b001, 32'hF0);
        step();
        flushA = 1'b0;
        drvA(1'b0, 3'b000, 32'h0);
        memA.ready = 1'b1;
        @(negedge clk);
        checkVal("fl_occ",     64'(occA), 64'd0);
        checkVal("fl_valid",   64'(memA.valid), 64'd0);
        checkVal("fl_memW",    64'(memA.ctrl.memWEn), 64'd0);
        checkVal("fl_inReady", 64'(exA.ready), 64'd1);
        step();
        step();

        // Flush together with freeze
        memA.ready = 1'b0;
        drvA(1'b1, 3'b001, 32'h11);
        step();
        drvA(1'b1, 3'b001, 32'h12);
        step();
        drvA(1'b1, 3'b001, 32'hF1);
        flushA = 1'b1;
        freezeA = 1'b1;
        @(negedge clk);
        checkVal("flfz_occPre", 64'(occA), 64'd2);
        step();
        flushA = 1'b0;
        freezeA = 1'b0;
        drvA(1'b0, 3'b000, 32'h0);
        @(negedge clk);
        checkVal("flfz_occ",   64'(occA), 64'd0);
        checkVal("flfz_valid", 64'(memA.valid), 64'd0);
        checkVal("flfz_memW",  64'(memA.ctrl.memWEn), 64'd0);
        step();

        // Flush from occupancy 1 while ready is high: the offered entry is still dropped
        drvA(1'b1, 3'b011, 32'h13);
        step();
        drvA(1'b1, 3'b001, 32'hF2);
        flushA = 1'b1;
        @(negedge clk);
        checkVal("fl1_occPre",   64'(occA), 64'd1);
        checkVal("fl1_inReady",  64'(exA.ready), 64'd1);
        step();
        flushA = 1'b0;
        drvA(1'b0, 3'b000, 32'h0);
        memA.ready = 1'b1;
        @(negedge clk);
        checkVal("fl1_occ",   64'(occA), 64'd0);
        checkVal("fl1_valid", 64'(memA.valid), 64'd0);
        step();
        step();

        // No-skid instance: combinational ready and head replacement
        memB.ready = 1'b0;
        drvB(1'b1, 3'b010, 64'h1111, 5'd3);
        @(negedge clk);
        checkVal("ns_inReadyEmpty", 64'(exB.ready), 64'd1);
        step();
        drvB(1'b1, 3'b101, 64'hFFFF_FFFF_0000_0001, 5'h1F);
        @(negedge clk);
        checkVal("ns_inReadyFull", 64'(exB.ready), 64'd0);
        checkVal("ns_occFull",     64'(occB), 64'd1);
        checkVal("ns_headOld",     memB.aluRes, 64'h1111);
        step();
        memB.ready = 1'b1;
        @(negedge clk);
        checkVal("ns_inReadyPass", 64'(exB.ready), 64'd1);
        step();
        drvB(1'b0, 3'b000, 64'h0, 5'h0);
        memB.ready = 1'b0;
        @(negedge clk);
        checkVal("ns_headNew", memB.aluRes, 64'hFFFF_FFFF_0000_0001);
        checkVal("ns_destNew", 64'(memB.dest), 64'h1F);
        checkVal("ns_occNew",  64'(occB), 64'd1);
        checkVal("ns_ctrlNew", 64'(memB.ctrl), 64'h5);
        step();
        freezeB = 1'b1;
        memB.ready = 1'b1;
        drvB(1'b1, 3'b000, 64'h2222, 5'd2);
        @(negedge clk);
        checkVal("ns_inReadyFrz", 64'(exB.ready), 64'd0);
        step();
        freezeB = 1'b0;
        drvB(1'b0, 3'b000, 64'h0, 5'h0);
        @(negedge clk);
        checkVal("ns_frzHeld", memB.aluRes, 64'hFFFF_FFFF_0000_0001);
        step();
        @(negedge clk);
        checkVal("ns_occEnd", 64'(occB), 64'd0);
        checkVal("ns_validEnd", 64'(memB.valid), 64'd0);

        checkVal("A_queueDrained", 64'(qA.size()), 64'd0);
        checkVal("B_queueDrained", 64'(qB.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
